// File: rtl/cmpgt_argmax.sv
// Streaming arg-max: scans a frame of len words and reports the largest value
// and its first position, in unsigned or two's-complement order.
module cmpgt_argmax #(
  parameter int WIDTH = 16,
  parameter int LENW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [LENW-1:0]  len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [LENW-1:0]  out_idx,
  output logic             out_empty,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_signed;
  logic [LENW-1:0]   r_len;
  logic [LENW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_max;
  logic [LENW-1:0]   r_idx;
  logic              r_empty;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  w_key_in;
  logic [WIDTH-1:0]  w_key_max;
  logic              w_gt;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_last     = w_accept && (r_cnt == r_len - LENW'(1));

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned comparator serves both modes.
  assign w_key_in  = {in_data[WIDTH-1] ^ r_signed, in_data[WIDTH-2:0]};
  assign w_key_max = {r_max[WIDTH-1]   ^ r_signed, r_max[WIDTH-2:0]};
  assign w_gt      = w_key_in > w_key_max;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_max    <= '0;
      r_idx    <= '0;
      r_empty  <= 1'b0;
    end else if (w_start_ok) begin
      r_signed <= is_signed;
      r_len    <= len;
      r_cnt    <= '0;
      r_empty  <= (len == '0);
      if (len == '0) begin
        r_max <= '0;
        r_idx <= '0;
      end
    end else if (w_accept) begin
      // Counter tops out at len, which always fits in LENW bits.
      r_cnt <= r_cnt + LENW'(1);
      if ((r_cnt == '0) || w_gt) begin
        r_max <= in_data;
        r_idx <= r_cnt;
      end
    end
  end

  assign in_ready  = (r_state == S_RUN);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_max   = r_max;
  assign out_idx   = r_idx;
  assign out_empty = r_empty;

endmodule

// File: tb/tb_cmpgt_argmax.sv
// Directed bench for cmpgt_argmax: a queue-based arg-max model plus a
// per-cycle compare process, pinned by hand-computed literal results.
module tb_cmpgt_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_max;
  logic [7:0]  out_idx;
  logic        out_empty;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_valid = 1'b0;
  logic [15:0] exp_max   = '0;
  logic [7:0]  exp_idx   = '0;
  logic        exp_empty = 1'b0;

  cmpgt_argmax #(.WIDTH(16), .LENW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_empty (out_empty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit gt(input logic [15:0] a, input logic [15:0] b, input bit s);
    if (s) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Every negedge: result visibility and, while a result is up, its content.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        check("out_max",   {16'd0, out_max},   {16'd0, exp_max});
        check("out_idx",   {24'd0, out_idx},   {24'd0, exp_idx});
        check("out_empty", {31'd0, out_empty}, {31'd0, exp_empty});
      end
    end
  end

  task automatic do_frame(input string name, input bit sgn, input logic [15:0] d[$],
                          input int stall, input int hold, input bit has_want,
                          input logic [15:0] want_max, input logic [7:0] want_idx);
    int n;
    int best;
    n    = d.size();
    best = 0;
    for (int i = 1; i < n; i++)
      if (gt(d[i], d[best], sgn)) best = i;
    exp_max   = (n != 0) ? d[best] : 16'd0;
    exp_idx   = (n != 0) ? 8'(best) : 8'd0;
    exp_empty = (n == 0);

    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; len = 8'(n);
    @(posedge clk); #1;
    start = 1'b0; is_signed = ~sgn; len = 8'($urandom);
    check({name, "/busy"}, {31'd0, busy}, 32'd1);

    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b0; start = 1'b1; len = 8'd0;
        @(posedge clk); #1;
      end
      start = 1'b0; in_valid = 1'b1; in_data = d[i];
      if (i == 0 || stall != 0) check({name, "/in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_valid = 1'b1;
    check({name, "/latency"}, {31'd0, out_valid}, 32'd1);
    check({name, "/in_ready_done"}, {31'd0, in_ready}, 32'd0);
    if (has_want) begin
      check({name, "/want_max"}, {16'd0, out_max}, {16'd0, want_max});
      check({name, "/want_idx"}, {24'd0, out_idx}, {24'd0, want_idx});
    end

    for (int h = 0; h < hold; h++) begin
      start = 1'b1; len = 8'($urandom);
      @(posedge clk); #1;
    end
    if (hold != 0) check({name, "/busy_hold"}, {31'd0, busy}, 32'd1);

    start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    check({name, "/valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, "/idle"},       {31'd0, busy},      32'd0);
  endtask

  initial begin
    logic [15:0] q[$];

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/in_ready",  {31'd0, in_ready},  32'd0);
    check("rst/busy",      {31'd0, busy},      32'd0);
    check("rst/out_max",   {16'd0, out_max},   32'd0);
    check("rst/out_idx",   {24'd0, out_idx},   32'd0);
    check("rst/out_empty", {31'd0, out_empty}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    q = {16'd3, 16'hFFFF, 16'd1, 16'd2};
    do_frame("u4", 1'b0, q, 0, 0, 1'b1, 16'hFFFF, 8'd1);
    do_frame("s4", 1'b1, q, 0, 0, 1'b1, 16'd3, 8'd0);

    q = {16'h8000, 16'h8000, 16'hFFFE};
    do_frame("s3_stall", 1'b1, q, 3, 0, 1'b1, 16'hFFFE, 8'd2);

    q = {16'd5, 16'd9, 16'd9, 16'd2};
    do_frame("u_tie", 1'b0, q, 1, 2, 1'b1, 16'd9, 8'd1);

    q.delete();
    do_frame("empty", 1'b0, q, 0, 5, 1'b1, 16'd0, 8'd0);
    check("empty/out_empty_lit", {31'd0, out_empty}, 32'd1);

    // Reset in the middle of a frame: outputs clear immediately.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'd9;
    @(posedge clk); #1;
    in_data = 16'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid/busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst/in_ready",  {31'd0, in_ready},  32'd0);
    check("mid_rst/busy",      {31'd0, busy},      32'd0);
    check("mid_rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst/out_max",   {16'd0, out_max},   32'd0);
    check("mid_rst/out_idx",   {24'd0, out_idx},   32'd0);
    check("mid_rst/out_empty", {31'd0, out_empty}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q = {16'd7};
    do_frame("after_rst", 1'b0, q, 0, 0, 1'b1, 16'd7, 8'd0);

    q.delete();
    for (int i = 0; i < 255; i++) q.push_back(16'(i - 128));
    do_frame("ramp255", 1'b1, q, 0, 0, 1'b1, 16'd126, 8'd254);

    for (int f = 0; f < 4; f++) begin
      q.delete();
      for (int i = 0; i < 6 + f; i++) q.push_back(16'($urandom));
      do_frame("rand", f[0], q, f % 2, 1, 1'b0, 16'd0, 8'd0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmpgt_argmax.md
CMPGT_ARGMAX -- requirements
Module: cmpgt_argmax

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter LENW, default 8, width of the frame-length and index fields.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  frame-start request, sampled only in IDLE.
REQ-006 SHALL have port is_signed  input  1  comparison mode (1 = two's complement), latched on accepted start.
REQ-007 SHALL have port len  input  LENW  number of elements in the frame, latched on accepted start.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  element value.
REQ-011 SHALL have port out_valid  output  1  result is valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out_max  output  WIDTH  largest element of the frame.
REQ-014 SHALL have port out_idx  output  LENW  zero-based position of out_max in the frame.
REQ-015 SHALL have port out_empty  output  1  result belongs to a zero-length frame.
REQ-016 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE, one-hot or encoded, with IDLE as the reset state.
REQ-018 In IDLE with start=1 and len!=0: latch is_signed and len, clear the beat counter, go to RUN next cycle.
REQ-019 In IDLE with start=1 and len=0: go to DONE with out_max=0, out_idx=0, out_empty=1.
REQ-020 in_ready SHALL be 1 only in RUN; a beat is accepted when in_valid and in_ready are both 1.
REQ-021 On the first accepted beat (counter=0): load max register with in_data unconditionally and set idx to 0.
REQ-022 On each later accepted beat: compare in_data > max with one shared greater-than comparator in the latched mode; if true, load max with in_data and idx with the counter value; otherwise hold.
REQ-023 Comparison SHALL be strict, so on equal values the earliest index is kept.
REQ-024 Unsigned mode SHALL compare raw WIDTH-bit magnitudes; signed mode SHALL treat the MSB as sign.
REQ-025 The beat counter SHALL increment once per accepted beat; on the accept where counter=len-1, go to DONE.
REQ-026 out_valid SHALL rise the cycle after the last beat is accepted; latency from last beat to out_valid is 1 cycle.
REQ-027 In DONE: out_valid=1, and out_max, out_idx and out_empty SHALL be held stable until out_valid and out_ready are both 1; then go to IDLE.
REQ-028 out_valid SHALL be 0 outside DONE; the next start SHALL be accepted in the cycle after the result handshake at the earliest.
REQ-029 start SHALL be ignored in RUN and DONE; changes to is_signed or len during a frame SHALL have no effect.
REQ-030 len=2^LENW-1 (maximum) SHALL be supported, with the counter never wrapping within a frame.
REQ-031 Cycles with in_valid=0 in RUN SHALL leave all state unchanged (stalls of any length).

Reset
REQ-032 On rst_n=0, regardless of the clock: state=IDLE, in_ready=0, out_valid=0, out_max=0, out_idx=0, out_empty=0, busy=0, counter=0, latched mode=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no result; a new frame after reset starts clean.

Verification
REQ-034 Unsigned, len=4, data 3,0xFFFF,1,2 -> out_max=0xFFFF, out_idx=1, out_empty=0, out_valid 1 cycle after 4th beat.
REQ-035 Signed, len=4, same data -> out_max=3, out_idx=0.
REQ-036 Signed, len=3, data 0x8000,0x8000,0xFFFE with in_valid stalls between beats -> out_max=0xFFFE, out_idx=2; ties keep the first index.
REQ-037 len=0 with start -> out_valid next cycle, out_empty=1, out_max=0, out_idx=0; hold out_ready=0 for 5 cycles -> outputs stable, start ignored.
REQ-038 Unsigned, len=5, assert rst_n=0 after 2 beats -> all outputs 0 at once; new frame len=1, data 7 -> out_max=7, out_idx=0.
REQ-039 Signed, len=255, data ramp -128..126 -> out_max=126, out_idx=254, no counter wrap.
